// File: rtl/load_store_unit.sv
// Load/store unit: one memory-stage request at a time, big-endian byte lanes,
// unaligned-word merges (LWL/LWR/SWL/SWR), misalignment faults and ram_ack timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic [3:0]  operation,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic [31:0] rt_data,
  output logic        result_valid,
  output logic [31:0] result_data,
  output logic        exception_address,
  output logic        timeout,
  output logic        stall,
  output logic        ram_enable,
  output logic        ram_write,
  output logic [31:0] ram_address,
  output logic [3:0]  ram_select,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  input  logic        ram_ack,
  output logic [1:0]  fsm_state
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_LWL = 4'd6;
  localparam logic [3:0] OP_LWR = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11;
  localparam logic [3:0] OP_SWR = 4'd12;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]    op_q;
  logic [1:0]    off_q;
  logic [31:0]   rt_q;
  logic [31:0]   addr_q;
  logic [3:0]    sel_q;
  logic [31:0]   wd_q;
  logic          wr_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   res_q;
  logic          exc_q;
  logic          tout_q;

  logic          op_valid;
  logic          misaligned;
  logic          accept;
  logic          expire;
  logic [3:0]    sel_d;
  logic [31:0]   wd_d;
  logic          wr_d;
  logic [31:0]   load_result;

  // Request side: decode, alignment check and lane steering for the accept cycle.
  logic [1:0]  req_k;
  logic [4:0]  req_sh;
  logic [4:0]  req_rsh;
  assign req_k   = address[1:0];
  assign req_sh  = {req_k, 3'b000};
  assign req_rsh = {~req_k, 3'b000};

  always_comb begin
    op_valid   = (operation >= OP_LB) && (operation <= OP_SWR);
    misaligned = 1'b0;
    case (operation)
      OP_LH, OP_LHU, OP_SH: misaligned = address[0];
      OP_LW, OP_SW:         misaligned = (address[1:0] != 2'b00);
      default:              misaligned = 1'b0;
    endcase
  end

  always_comb begin
    sel_d = 4'b1111;
    wd_d  = 32'h0;
    wr_d  = 1'b0;
    case (operation)
      OP_SB: begin
        wr_d  = 1'b1;
        sel_d = 4'b1000 >> req_k;
        wd_d  = {4{store_data[7:0]}};
      end
      OP_SH: begin
        wr_d  = 1'b1;
        sel_d = req_k[1] ? 4'b0011 : 4'b1100;
        wd_d  = {2{store_data[15:0]}};
      end
      OP_SW: begin
        wr_d  = 1'b1;
        wd_d  = store_data;
      end
      OP_SWL: begin
        wr_d  = 1'b1;
        sel_d = 4'b1111 >> req_k;
        wd_d  = rt_data >> req_sh;
      end
      OP_SWR: begin
        wr_d  = 1'b1;
        sel_d = 4'b1111 << (~req_k);
        wd_d  = rt_data << req_rsh;
      end
      default: ;
    endcase
  end

  // Response side: aligns the returned word using the registered request.
  logic [4:0]  rsp_sh;
  logic [4:0]  rsp_rsh;
  logic [31:0] byte_word;
  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;
  assign rsp_sh    = {off_q, 3'b000};
  assign rsp_rsh   = {~off_q, 3'b000};
  assign byte_word = ram_read_data >> rsp_rsh;
  assign rsp_byte  = byte_word[7:0];
  assign rsp_half  = off_q[1] ? ram_read_data[15:0] : ram_read_data[31:16];

  always_comb begin
    load_result = 32'h0;
    case (op_q)
      OP_LB:  load_result = {{24{rsp_byte[7]}}, rsp_byte};
      OP_LBU: load_result = {24'h0, rsp_byte};
      OP_LH:  load_result = {{16{rsp_half[15]}}, rsp_half};
      OP_LHU: load_result = {16'h0, rsp_half};
      OP_LW:  load_result = ram_read_data;
      OP_LWL: load_result = (ram_read_data << rsp_sh) | (rt_q & ~(32'hFFFF_FFFF << rsp_sh));
      OP_LWR: load_result = (ram_read_data >> rsp_rsh) | (rt_q & ~(32'hFFFF_FFFF >> rsp_rsh));
      default: load_result = 32'h0;
    endcase
  end

  // Handshake: a request transfers on a rising edge where request_valid and
  // request_ready are both high; only IDLE is ready, and operation "none" is dropped.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (request_valid && op_valid) begin
          accept  = 1'b1;
          state_d = misaligned ? RESPOND : ACCESS;
        end
      end
      ACCESS: begin
        if (ram_ack) begin
          state_d = RESPOND;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          expire  = 1'b1;
          state_d = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 4'h0;
      off_q   <= 2'b00;
      rt_q    <= 32'h0;
      addr_q  <= 32'h0;
      sel_q   <= 4'h0;
      wd_q    <= 32'h0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= 32'h0;
      exc_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= operation;
        off_q  <= address[1:0];
        rt_q   <= rt_data;
        addr_q <= {address[31:2], 2'b00};
        sel_q  <= sel_d;
        wd_q   <= wd_d;
        wr_q   <= wr_d;
        cnt_q  <= '0;
        res_q  <= 32'h0;
        exc_q  <= misaligned;
        tout_q <= 1'b0;
      end else if (state_q == ACCESS) begin
        cnt_q <= cnt_q + 1'b1;
        if (ram_ack) begin
          res_q <= load_result;
        end else if (expire) begin
          tout_q <= 1'b1;
        end
      end
    end
  end

  logic in_idle;
  logic in_access;
  logic in_respond;
  assign in_idle    = (state_q == IDLE) && !reset;
  assign in_access  = (state_q == ACCESS);
  assign in_respond = (state_q == RESPOND);

  assign request_ready     = in_idle;
  assign stall             = in_access || (in_idle && request_valid && op_valid && !misaligned);
  assign result_valid      = in_respond;
  assign result_data       = in_respond ? res_q : 32'h0;
  assign exception_address = in_respond && exc_q;
  assign timeout           = in_respond && tout_q;
  assign ram_enable        = in_access;
  assign ram_write         = in_access && wr_q;
  assign ram_address       = in_access ? addr_q : 32'h0;
  assign ram_select        = in_access ? sel_q : 4'h0;
  assign ram_write_data    = in_access ? wd_q : 32'h0;
  assign fsm_state         = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: driver tasks push expected responses,
// a negedge monitor pops and compares every result_valid pulse.
module tb_load_store_unit;

  localparam int TIMEOUT_CYCLES = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        request_valid;
  logic        request_ready;
  logic [3:0]  operation;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] rt_data;
  logic        result_valid;
  logic [31:0] result_data;
  logic        exception_address;
  logic        timeout;
  logic        stall;
  logic        ram_enable;
  logic        ram_write;
  logic [31:0] ram_address;
  logic [3:0]  ram_select;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        ram_ack;
  logic [1:0]  fsm_state;

  load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_ready(request_ready),
    .operation(operation), .address(address),
    .store_data(store_data), .rt_data(rt_data),
    .result_valid(result_valid), .result_data(result_data),
    .exception_address(exception_address), .timeout(timeout), .stall(stall),
    .ram_enable(ram_enable), .ram_write(ram_write), .ram_address(ram_address),
    .ram_select(ram_select), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data), .ram_ack(ram_ack),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  // Scoreboard monitor: {result_data, exception_address, timeout}
  always @(negedge clock) begin
    if (result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: got result_valid=1 data=%08h expected no response", result_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_data", result_data, mon_e[33:2]);
        chk1("exception_address", exception_address, mon_e[1]);
        chk1("timeout", timeout, mon_e[0]);
      end
    end
  end

  // Driver: ack_at = ACCESS cycle (1-based) carrying ram_ack, 0 = never.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rt, input logic [31:0] word,
                        input int ack_at, input logic acc, input logic [3:0] esel,
                        input logic [31:0] ewd, input logic ewr, input logic [31:0] eres,
                        input logic eexc, input logic etout);
    int cycles;
    logic [31:0] eaddr;
    eaddr = {addr[31:2], 2'b00};
    exp_q.push_back({eres, eexc, etout});
    @(negedge clock);
    request_valid = 1'b1;
    operation     = op;
    address       = addr;
    store_data    = sd;
    rt_data       = rt;
    #1;
    chk1({name, " request_ready"}, request_ready, 1'b1);
    chk1({name, " accept_stall"}, stall, acc);
    @(negedge clock);
    request_valid = 1'b0;
    operation     = 4'd0;
    cycles        = 0;
    if (acc) begin
      while (ram_enable === 1'b1 && cycles < 40) begin
        cycles++;
        if (cycles == 1 || cycles == ack_at) begin
          chk({name, " ram_address"}, ram_address, eaddr);
          chk({name, " ram_select"}, {28'h0, ram_select}, {28'h0, esel});
          chk({name, " ram_write_data"}, ram_write_data, ewd);
          chk1({name, " ram_write"}, ram_write, ewr);
        end
        if (cycles == ack_at) begin
          ram_ack       = 1'b1;
          ram_read_data = word;
        end
        @(negedge clock);
        ram_ack       = 1'b0;
        ram_read_data = 32'h0;
      end
      chk({name, " enable_cycles"}, 32'(cycles), 32'((ack_at == 0) ? TIMEOUT_CYCLES : ack_at));
    end else begin
      chk1({name, " ram_enable"}, ram_enable, 1'b0);
    end
    chk1({name, " result_valid"}, result_valid, 1'b1);
    chk1({name, " respond_ready"}, request_ready, 1'b0);
    chk1({name, " respond_stall"}, stall, 1'b0);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    request_valid = 1'b0;
    operation = 4'd0;
    address = 32'h0;
    store_data = 32'h0;
    rt_data = 32'h0;
    ram_read_data = 32'h0;
    ram_ack = 1'b0;
    #1;
    chk1("reset request_ready", request_ready, 1'b0);
    chk1("reset ram_enable", ram_enable, 1'b0);
    chk1("reset stall", stall, 1'b0);
    chk1("reset result_valid", result_valid, 1'b0);
    chk("reset fsm_state", {30'h0, fsm_state}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk1("post_reset request_ready", request_ready, 1'b1);

    // Operation none and reserved codes are ignored
    @(negedge clock);
    request_valid = 1'b1;
    operation = 4'd0;
    #1;
    chk1("none stall", stall, 1'b0);
    @(negedge clock);
    operation = 4'd13;
    #1;
    chk1("reserved stall", stall, 1'b0);
    @(negedge clock);
    request_valid = 1'b0;
    operation = 4'd0;
    chk1("ignored ram_enable", ram_enable, 1'b0);
    chk1("ignored request_ready", request_ready, 1'b1);

    //      name    op     addr          store_data    rt            ram word      ack acc sel      wdata         wr    result        exc   tout
    run_op("LB",    4'd1,  32'h0000_0001, 32'h0,        32'h0,        32'h4488_9977, 1, 1, 4'b1111, 32'h0,        1'b0, 32'hFFFF_FF88, 1'b0, 1'b0);
    run_op("LBU",   4'd2,  32'h0000_0001, 32'h0,        32'h0,        32'h4488_9977, 1, 1, 4'b1111, 32'h0,        1'b0, 32'h0000_0088, 1'b0, 1'b0);
    run_op("LB3",   4'd1,  32'h0000_0003, 32'h0,        32'h0,        32'h4488_9977, 1, 1, 4'b1111, 32'h0,        1'b0, 32'h0000_0077, 1'b0, 1'b0);
    run_op("LWL",   4'd6,  32'h0000_0001, 32'h0,        32'h0000_8899, 32'h4455_6677, 1, 1, 4'b1111, 32'h0,        1'b0, 32'h5566_7799, 1'b0, 1'b0);
    run_op("LWR",   4'd7,  32'h0000_0002, 32'h0,        32'h0000_8899, 32'h4455_6677, 2, 1, 4'b1111, 32'h0,        1'b0, 32'h0044_5566, 1'b0, 1'b0);
    run_op("LH",    4'd3,  32'h0000_0002, 32'h0,        32'h0,        32'h4488_9977, 3, 1, 4'b1111, 32'h0,        1'b0, 32'hFFFF_9977, 1'b0, 1'b0);
    run_op("LHU",   4'd4,  32'h0000_0000, 32'h0,        32'h0,        32'h4488_9977, 1, 1, 4'b1111, 32'h0,        1'b0, 32'h0000_4488, 1'b0, 1'b0);
    run_op("LW",    4'd5,  32'h1000_0008, 32'h0,        32'h0,        32'hDEAD_BEEF, 2, 1, 4'b1111, 32'h0,        1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_op("SH",    4'd9,  32'h0000_0002, 32'h1234_AABB, 32'h0,        32'h0,         1, 1, 4'b0011, 32'hAABB_AABB, 1'b1, 32'h0,        1'b0, 1'b0);
    run_op("SWR",   4'd12, 32'h0000_0001, 32'h0,        32'h4455_6677, 32'h0,         1, 1, 4'b1100, 32'h6677_0000, 1'b1, 32'h0,        1'b0, 1'b0);
    run_op("SB",    4'd8,  32'h0000_0003, 32'h0000_00A5, 32'h0,        32'h0,         1, 1, 4'b0001, 32'hA5A5_A5A5, 1'b1, 32'h0,        1'b0, 1'b0);
    run_op("SWL",   4'd11, 32'h0000_0002, 32'h0,        32'h1122_3344, 32'h0,         2, 1, 4'b0011, 32'h0000_1122, 1'b1, 32'h0,        1'b0, 1'b0);
    run_op("LW_mis",4'd5,  32'h0000_0006, 32'h0,        32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0);
    run_op("SH_mis",4'd9,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0);
    run_op("LW_to", 4'd5,  32'h0000_0000, 32'h0,        32'h0,        32'h1234_5678, 0, 1, 4'b1111, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1);
    run_op("LW_a15",4'd5,  32'h0000_0000, 32'h0,        32'h0,        32'h1234_5678, 15,1, 4'b1111, 32'h0,        1'b0, 32'h1234_5678, 1'b0, 1'b0);

    // Reset pulsed mid-cycle during the third ACCESS cycle
    @(negedge clock);
    request_valid = 1'b1;
    operation = 4'd5;
    address = 32'h0000_0000;
    @(negedge clock);
    request_valid = 1'b0;
    operation = 4'd0;
    repeat (2) @(negedge clock);
    chk1("pre_reset ram_enable", ram_enable, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("mid_reset ram_enable", ram_enable, 1'b0);
    chk1("mid_reset request_ready", request_ready, 1'b0);
    chk1("mid_reset stall", stall, 1'b0);
    chk1("mid_reset result_valid", result_valid, 1'b0);
    chk("mid_reset ram_select", {28'h0, ram_select}, 32'h0);
    chk("mid_reset ram_address", ram_address, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk1("after_reset request_ready", request_ready, 1'b1);
    chk1("after_reset ram_enable", ram_enable, 1'b0);
    run_op("SW",    4'd10, 32'h0000_0000, 32'hCAFE_F00D, 32'h0,        32'h0,         1, 1, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0,        1'b0, 1'b0);

    repeat (3) @(negedge clock);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 15, number of ACCESS cycles allowed without ram_ack before the access is abandoned.
REQ-002 clock  in  1  single clock for the block; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 request_valid  in  1  memory-stage request present.
REQ-005 request_ready  out  1  block accepts a request this cycle.
REQ-006 operation  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR, 8 SB, 9 SH, 10 SW, 11 SWL, 12 SWR; 13-15 treated as none.
REQ-007 address  in  32  byte address.
REQ-008 store_data  in  32  source for SB/SH/SW.
REQ-009 rt_data  in  32  current rt value; merge source for LWL/LWR, data source for SWL/SWR.
REQ-010 result_valid  out  1  one-cycle completion pulse.
REQ-011 result_data  out  32  aligned load result; 0 for stores, faults and timeouts.
REQ-012 exception_address  out  1  misaligned access, valid with result_valid.
REQ-013 timeout  out  1  ram_ack timeout, valid with result_valid.
REQ-014 stall  out  1  holds the upstream pipeline.
REQ-015 ram_enable, ram_write  out  1 each  RAM request and write strobe.
REQ-016 ram_address  out  32  word address, {address[31:2], 2'b00}.
REQ-017 ram_select  out  4  byte enables; bit 3 = byte offset 0 (big-endian).
REQ-018 ram_write_data  out  32  lane-replicated store data.
REQ-019 ram_read_data  in  32  RAM read word; ram_ack  in  1  RAM completion.

Function
REQ-020 FSM states: IDLE, ACCESS, RESPOND; request_ready = 1 only in IDLE.
REQ-021 IDLE, request_valid with operation none: ignored, no response, no stall.
REQ-022 IDLE, valid operation, misaligned (LH/LHU/SH with address[0]=1; LW/SW with address[1:0]!=0): no RAM access; go to RESPOND with exception_address=1 and result_data=0.
REQ-023 IDLE, valid aligned operation: register operation, offset, store/rt data; go to ACCESS; stall=1 combinationally in this accept cycle.
REQ-024 ACCESS: ram_enable=1; ram_address, ram_write, ram_select and ram_write_data registered and held stable until exit; stall=1.
REQ-025 ACCESS with ram_ack=1: capture ram_read_data, compute result, go to RESPOND; ram_enable drops on that edge.
REQ-026 Cycle counter cleared on entry to ACCESS; on the TIMEOUT_CYCLES-th ACCESS cycle without ram_ack, go to RESPOND with timeout=1 and result_data=0; ram_ack in that same cycle wins (normal completion).
REQ-027 RESPOND: result_valid=1 for exactly one cycle, stall=0, request_ready=0; return to IDLE next cycle; requests arriving here are not accepted.
REQ-028 Minimum latency: accept at cycle N, ram_ack at N+1 -> result_valid at N+2.
REQ-029 Loads: ram_write=0, ram_select=4'b1111, ram_write_data=0.
REQ-030 Loads, offset k=address[1:0], word W: LB/LBU take W[31-8k -: 8], sign/zero-extended; LH/LHU take W[31:16] (k=0) or W[15:0] (k=2), sign/zero-extended; LW returns W.
REQ-031 LWL: k=0 W; k=1 {W[23:0],rt[7:0]}; k=2 {W[15:0],rt[15:0]}; k=3 {W[7:0],rt[23:0]}.
REQ-032 LWR: k=0 {rt[31:8],W[31:24]}; k=1 {rt[31:16],W[31:16]}; k=2 {rt[31:24],W[31:8]}; k=3 W.
REQ-033 Stores: ram_write=1; SB select 4'b1000>>k, data {4{store_data[7:0]}}; SH select 1100 (k=0) / 0011 (k=2), data {2{store_data[15:0]}}; SW select 1111, data store_data.
REQ-034 SWL: select 4'b1111>>k, data rt_data>>(8k); SWR: select 1000/1100/1110/1111 for k=0..3, data rt_data<<(8(3-k)).
REQ-035 Stores complete with result_valid=1, result_data=0.

Reset
REQ-036 reset=1 forces IDLE immediately, independent of clock; all outputs 0 (including request_ready and ram_enable) while reset is held.
REQ-037 Reset during ACCESS abandons the access with no result_valid; first cycle after release is IDLE with request_ready=1.

Verification
REQ-038 RAM word 0x44889977, LB addr 0x1 -> result 0xFFFFFF88; LBU addr 0x1 -> 0x00000088; ack at N+1 -> result_valid at N+2.
REQ-039 RAM word 0x44556677, rt 0x00008899: LWL addr 0x1 -> 0x55667799; LWR addr 0x2 -> 0x00445566.
REQ-040 SH addr 0x2, store_data 0x1234AABB -> ram_select 0011, ram_write_data 0xAABBAABB; SWR addr 0x1, rt 0x44556677 -> select 1100, data 0x66770000.
REQ-041 LW addr 0x6 -> ram_enable never asserted; result_valid next cycle with exception_address=1, result_data=0.
REQ-042 ram_ack held low -> ram_enable high exactly 15 cycles, then result_valid with timeout=1; ack in cycle 15 -> normal result, timeout=0.
REQ-043 reset pulsed in 3rd ACCESS cycle -> all outputs 0 asynchronously, no result_valid; a following SW addr 0x0 completes normally with select 1111.
